// File: rtl/bram_burst_ctrl_if.sv
// Stream and memory signal bundle for the burst controller.
// The controller side uses the master modport; the producer, consumer and memory side use the slave modport.
interface bram_burst_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  // Input word stream (producer -> controller)
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  // Output word stream (controller -> consumer)
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  // Block memory port (controller -> memory; read data comes back)
  logic              wen_s;
  logic              ren_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] datw_s;
  logic [DATA_W-1:0] datr_s;

  modport master (
    input  s_valid, s_data, s_last, m_ready, datr_s,
    output s_ready, m_valid, m_data, m_last, wen_s, ren_s, addr_s, datw_s
  );

  modport slave (
    output s_valid, s_data, s_last, m_ready, datr_s,
    input  s_ready, m_valid, m_data, m_last, wen_s, ren_s, addr_s, datw_s
  );
endinterface

// File: rtl/bram_burst_ctrl.sv
// Burst sequencer in front of a single-port block memory.
// It fills the memory from a valid/ready stream, then replays the stored burst in order.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_FILL     | accepting input words; each accepted word is written at once
// ST_RD_FIRST | one cycle: issue the read of word 0 so its data is ready next
// ST_DRAIN    | presenting datr_s; each handshake prefetches the next word
module bram_burst_ctrl #(
  parameter int DEPTH      = 8,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int ADDR_SHIFT = 2
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  bram_burst_ctrl_if.master      bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_FILL     = 2'd0,
    ST_RD_FIRST = 2'd1,
    ST_DRAIN    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             m_valid_q, m_valid_d;

  logic              s_ready_c;
  logic              wen_c;
  logic              ren_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] datw_c;
  logic              m_last_c;
  logic              busy_c;

  logic [PTR_W-1:0]  rd_next;
  logic              at_last;

  // Word index to byte address; upper address bits stay zero by construction.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [PTR_W-1:0] idx);
    return ADDR_W'(idx) << ADDR_SHIFT;
  endfunction

  assign rd_next = rd_ptr_q + PTR_W'(1);
  assign at_last = m_valid_q && ({1'b0, rd_ptr_q} == (count_q - CNT_W'(1)));

  // State and pointer registers; reset discards any burst in progress.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= ST_FILL;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      m_valid_q <= m_valid_d;
    end
  end

  // Next-state logic and the memory and stream strobes, which depend only on the current state and inputs.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    m_valid_d = m_valid_q;
    s_ready_c = 1'b0;
    wen_c     = 1'b0;
    ren_c     = 1'b0;
    addr_c    = '0;
    datw_c    = '0;
    m_last_c  = 1'b0;
    busy_c    = 1'b0;

    case (state_q)
      ST_FILL: begin
        s_ready_c = 1'b1;
        if (bus.s_valid) begin
          wen_c  = 1'b1;
          datw_c = bus.s_data;
          addr_c = word_addr(wr_ptr_q);
          // An explicit s_last and a full memory end the burst the same way.
          if (bus.s_last || (wr_ptr_q == LAST_IDX)) begin
            count_d  = {1'b0, wr_ptr_q} + CNT_W'(1);
            wr_ptr_d = '0;
            state_d  = ST_RD_FIRST;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
        end
      end

      ST_RD_FIRST: begin
        busy_c    = 1'b1;
        ren_c     = 1'b1;
        addr_c    = '0;
        rd_ptr_d  = '0;
        m_valid_d = 1'b1;
        state_d   = ST_DRAIN;
      end

      ST_DRAIN: begin
        busy_c   = 1'b1;
        m_last_c = at_last;
        // The read of the next word is issued on the handshake, so its data lands exactly when it is presented.
        // While m_ready is low no read is issued and the memory keeps showing the current word.
        if (m_valid_q && bus.m_ready) begin
          if (at_last) begin
            m_valid_d = 1'b0;
            rd_ptr_d  = '0;
            state_d   = ST_FILL;
          end else begin
            ren_c    = 1'b1;
            addr_c   = word_addr(rd_next);
            rd_ptr_d = rd_next;
          end
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  assign bus.s_ready = s_ready_c;
  assign bus.wen_s   = wen_c;
  assign bus.ren_s   = ren_c;
  assign bus.addr_s  = addr_c;
  assign bus.datw_s  = datw_c;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = bus.datr_s;
  assign bus.m_last  = m_last_c;
  assign busy        = busy_c;
  assign count       = count_q;

endmodule

// File: tb/tb_bram_burst_ctrl.sv
// Self-checking bench for bram_burst_ctrl with a behavioural block memory.
// Each burst is a list of words: it must be written at word_index*4, then come back in order, with m_last on the final word.
module tb_bram_burst_ctrl;
  localparam int DEPTH      = 8;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int ADDR_SHIFT = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       busy;
  logic [3:0] count;

  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] words [DEPTH];
  bit                pat [4];

  bram_burst_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  bram_burst_ctrl #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ADDR_SHIFT(ADDR_SHIFT)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus),
    .busy(busy),
    .count(count)
  );

  always #5 sys_clk = ~sys_clk;

  // Block memory model: synchronous write, registered read address, read data held until the next read.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] datr_q = '0;
  assign bus.datr_s = datr_q;
  always @(posedge sys_clk) begin
    if (bus.wen_s) mem[bus.addr_s[ADDR_SHIFT +: 3]] <= bus.datw_s;
    if (bus.ren_s) datr_q <= mem[bus.addr_s[ADDR_SHIFT +: 3]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Feed words[0..n-1]; gap_mode 0 = back-to-back, 1 = every other cycle, 2 = random.
  task automatic fill_burst(input int n, input bit use_last, input int gap_mode);
    int idx = 0;
    int cyc = 0;
    bit v;
    while (idx < n && cyc < 100) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.s_valid = v;
      bus.s_data  = v ? words[idx] : $urandom;
      bus.s_last  = v ? (use_last && idx == n - 1) : 1'($urandom_range(0, 1));
      @(negedge sys_clk);
      chk("fill_s_ready", bus.s_ready, 1);
      chk("fill_busy", busy, 0);
      chk("fill_m_valid", bus.m_valid, 0);
      chk("fill_ren", bus.ren_s, 0);
      chk("fill_wen", bus.wen_s, v);
      chk("fill_addr", bus.addr_s, v ? (idx << ADDR_SHIFT) : 0);
      if (v) begin
        chk("fill_datw", bus.datw_s, words[idx]);
        idx++;
      end
      step();
      cyc++;
    end
    chk("fill_accepted", idx, n);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    // Cycle after the last accept: read of word 0 issued, output not yet valid.
    @(negedge sys_clk);
    chk("rdf_ren", bus.ren_s, 1);
    chk("rdf_addr", bus.addr_s, 0);
    chk("rdf_wen", bus.wen_s, 0);
    chk("rdf_s_ready", bus.s_ready, 0);
    chk("rdf_busy", busy, 1);
    chk("rdf_m_valid", bus.m_valid, 0);
    chk("rdf_count", count, n);
    step();
  endtask

  // Consume stop_at words of an n-word burst; ready_mode 0 = always, 1 = 1,0,0,1 pattern, 2 = random.
  task automatic drain_burst(input int n, input int ready_mode, input int stop_at);
    int  out = 0;
    int  cyc = 0;
    bit  r;
    bit  exp_ren;
    while (out < stop_at && cyc < 200) begin
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = pat[cyc % 4];
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.m_ready = r;
      @(negedge sys_clk);
      chk("drain_m_valid", bus.m_valid, 1);
      chk("drain_busy", busy, 1);
      chk("drain_s_ready", bus.s_ready, 0);
      chk("drain_wen", bus.wen_s, 0);
      chk("drain_count", count, n);
      chk("drain_m_data", bus.m_data, words[out]);
      chk("drain_m_last", bus.m_last, (out == n - 1));
      exp_ren = r && (out < n - 1);
      chk("drain_ren", bus.ren_s, exp_ren);
      chk("drain_addr", bus.addr_s, exp_ren ? ((out + 1) << ADDR_SHIFT) : 0);
      chk("wen_ren_excl", bus.wen_s & bus.ren_s, 0);
      if (r) out++;
      step();
      cyc++;
    end
    chk("drain_words", out, stop_at);
    bus.m_ready = 1'b0;
    if (stop_at == n) begin
      @(negedge sys_clk);
      chk("post_s_ready", bus.s_ready, 1);
      chk("post_m_valid", bus.m_valid, 0);
      chk("post_busy", busy, 0);
      chk("post_m_last", bus.m_last, 0);
      chk("post_ren", bus.ren_s, 0);
      step();
    end
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge sys_clk);
    chk({tag, "_s_ready"}, bus.s_ready, 1);
    chk({tag, "_m_valid"}, bus.m_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_wen"}, bus.wen_s, 0);
    chk({tag, "_ren"}, bus.ren_s, 0);
    chk({tag, "_addr"}, bus.addr_s, 0);
    chk({tag, "_m_last"}, bus.m_last, 0);
  endtask

  initial begin
    int n;
    bit ul;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    sys_rst     = 1'b1;
    step();
    check_reset_state("reset");
    step();
    sys_rst = 1'b0;
    step();

    // Full burst without s_last: forced end at the memory depth.
    for (int i = 0; i < DEPTH; i++) words[i] = 32'hA0 + i;
    fill_burst(8, 1'b0, 0);
    drain_burst(8, 0, 8);

    // Short burst ended by s_last.
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    fill_burst(3, 1'b1, 0);
    drain_burst(3, 0, 3);

    // Single-word burst.
    words[0] = 32'hDEADBEEF;
    fill_burst(1, 1'b1, 0);
    drain_burst(1, 0, 1);

    // Back-pressure on the output: m_ready 1,0,0,1.
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    fill_burst(4, 1'b1, 0);
    drain_burst(4, 1, 4);

    // Reset in the middle of a drain, after 2 of 5 words.
    for (int i = 0; i < 5; i++) words[i] = 32'hC0 + i;
    fill_burst(5, 1'b1, 0);
    drain_burst(5, 0, 2);
    sys_rst = 1'b1;
    check_reset_state("midrst");
    step();
    sys_rst = 1'b0;
    words[0] = 32'h5; words[1] = 32'h6;
    fill_burst(2, 1'b1, 0);
    drain_burst(2, 0, 2);

    // Input gaps: valid every other cycle, addresses must stay contiguous.
    for (int i = 0; i < 6; i++) words[i] = $urandom;
    fill_burst(6, 1'b1, 1);
    drain_burst(6, 0, 6);

    // Random bursts with random gaps and random back-pressure.
    for (int k = 0; k < 10; k++) begin
      n  = $urandom_range(1, DEPTH);
      ul = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
      fill_burst(n, ul, 2);
      drain_burst(n, 2, n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
